// File: rtl/mem_req_arbiter_if.sv
// Memory request arbiter bus interface.
//
// Bundles every handshake and data signal that passes between the arbiter and
// its surroundings. The ring slot, the display and auxiliary requesters, the
// DDR address FIFO and the status outputs all live here.
//   slave  : arbiter side. It receives the requests and drives the acks, the
//            FIFO write and the status.
//   master : environment side. It drives the requests and observes the
//            arbiter outputs.
// Clock and reset are not part of the bundle and stay plain module ports.
interface mem_req_arbiter_if #(
  parameter int AW = 26
);
  logic          ringValid;
  logic [AW-1:0] ringAddr;
  logic          ringRead;

  logic          dispReq;
  logic [AW-1:0] dispAddr;
  logic          dispAck;

  logic          auxReq;
  logic [AW-1:0] auxAddr;
  logic          auxRead;
  logic          auxAck;

  logic          inhibit;
  logic          afFull;
  logic          rdRetire;

  logic          afWrite;
  logic [AW-1:0] afAddr;
  logic          afRead;
  logic [1:0]    afSrc;
  logic [5:0]    rif;
  logic          halted;
  logic          overflow;

  modport slave (
    input  ringValid, ringAddr, ringRead,
    input  dispReq, dispAddr,
    input  auxReq, auxAddr, auxRead,
    input  inhibit, afFull, rdRetire,
    output dispAck, auxAck,
    output afWrite, afAddr, afRead, afSrc,
    output rif, halted, overflow
  );

  modport master (
    output ringValid, ringAddr, ringRead,
    output dispReq, dispAddr,
    output auxReq, auxAddr, auxRead,
    output inhibit, afFull, rdRetire,
    input  dispAck, auxAck,
    input  afWrite, afAddr, afRead, afSrc,
    input  rif, halted, overflow
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Memory request arbiter.
//
// This block merges three address sources into the DDR address FIFO.
// - The ring slot cannot be stalled. It is always issued.
// - The display controller and the auxiliary requester share the remaining
//   cycles in round-robin order.
// - The arbiter counts reads in flight (rif). When the count is too high, it
//   stops granting local reads.
// - The inhibit input drains the arbiter and then halts it.
// A grant in cycle N acks the requester in cycle N. The registered FIFO write
// (afWrite/afAddr/afRead/afSrc) follows in cycle N+1.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high reset
//   arbBus : mem_req_arbiter_if.slave. It carries the ring, display, aux,
//            inhibit, FIFO and status signals.
module mem_req_arbiter #(
  parameter int MAX_RIF = 32,
  parameter int AW      = 26
) (
  input  logic               clock,
  input  logic               reset,
  mem_req_arbiter_if.slave   arbBus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [6:0] MAX_RIF_W = 7'(MAX_RIF);
  localparam logic [1:0] SRC_RING  = 2'd0;
  localparam logic [1:0] SRC_DISP  = 2'd1;
  localparam logic [1:0] SRC_AUX   = 2'd2;

  state_e        state_q, state_d;
  logic          afWrite_q, afWrite_d;
  logic [AW-1:0] afAddr_q, afAddr_d;
  logic          afRead_q, afRead_d;
  logic [1:0]    afSrc_q, afSrc_d;
  logic [5:0]    rif_q, rif_d;
  logic          overflow_q, overflow_d;
  // Round-robin pointer: 0 favours display, 1 favours aux.
  logic          rrPtr_q, rrPtr_d;

  logic          issueRead;
  logic [6:0]    rifPlusPending;
  logic          readRoom;
  logic          localOk;
  logic          dispElig, auxElig;
  logic          grantRing, grantDisp, grantAux;

  // Grant selection.
  // A read sits on the FIFO output for one cycle before rif counts it. That
  // read is added as pendingIssue so the limit is never overshot. Every grant
  // is suppressed while reset is high, so no stale write can appear after
  // reset.
  always_comb begin
    issueRead      = afWrite_q & afRead_q;
    rifPlusPending = {1'b0, rif_q} + {6'd0, issueRead};
    readRoom       = (rifPlusPending < MAX_RIF_W);
    localOk        = !reset && !arbBus.ringValid && !arbBus.afFull && (state_q == RUN);
    dispElig       = localOk && arbBus.dispReq && readRoom;
    auxElig        = localOk && arbBus.auxReq && (!arbBus.auxRead || readRoom);
    grantRing      = !reset && arbBus.ringValid;
    grantDisp      = dispElig && (!auxElig || !rrPtr_q);
    grantAux       = auxElig && (!dispElig || rrPtr_q);
  end

  // Next FIFO entry and round-robin pointer.
  // When nothing is granted, afAddr, afRead and afSrc keep their last values.
  always_comb begin
    afWrite_d = grantRing | grantDisp | grantAux;
    afAddr_d  = afAddr_q;
    afRead_d  = afRead_q;
    afSrc_d   = afSrc_q;
    rrPtr_d   = rrPtr_q;
    if (grantRing) begin
      afAddr_d = arbBus.ringAddr;
      afRead_d = arbBus.ringRead;
      afSrc_d  = SRC_RING;
    end else if (grantDisp) begin
      afAddr_d = arbBus.dispAddr;
      afRead_d = 1'b1;
      afSrc_d  = SRC_DISP;
      rrPtr_d  = 1'b1;
    end else if (grantAux) begin
      afAddr_d = arbBus.auxAddr;
      afRead_d = arbBus.auxRead;
      afSrc_d  = SRC_AUX;
      rrPtr_d  = 1'b0;
    end
  end

  // Reads-in-flight counter.
  // The counter changes when a read is on the FIFO output or when a read
  // retires. An increment and a decrement in the same cycle cancel out.
  // A move past 63 or below 0 leaves the count unchanged and sets the sticky
  // overflow flag instead.
  always_comb begin
    rif_d      = rif_q;
    overflow_d = overflow_q;
    if (issueRead && !arbBus.rdRetire) begin
      if (rif_q == 6'd63) begin
        overflow_d = 1'b1;
      end else begin
        rif_d = rif_q + 6'd1;
      end
    end else if (!issueRead && arbBus.rdRetire) begin
      if (rif_q == 6'd0) begin
        overflow_d = 1'b1;
      end else begin
        rif_d = rif_q - 6'd1;
      end
    end
  end

  // Drain/halt state machine.
  // DRAIN waits for rif to reach zero and for the FIFO output to go idle
  // before it enters HALT. Clearing inhibit always returns to RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (arbBus.inhibit) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!arbBus.inhibit) begin
          state_d = RUN;
        end else if ((rif_q == 6'd0) && !afWrite_q) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (!arbBus.inhibit) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      afWrite_q  <= 1'b0;
      afAddr_q   <= '0;
      afRead_q   <= 1'b0;
      afSrc_q    <= SRC_RING;
      rif_q      <= 6'd0;
      overflow_q <= 1'b0;
      rrPtr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      afWrite_q  <= afWrite_d;
      afAddr_q   <= afAddr_d;
      afRead_q   <= afRead_d;
      afSrc_q    <= afSrc_d;
      rif_q      <= rif_d;
      overflow_q <= overflow_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign arbBus.dispAck  = grantDisp;
  assign arbBus.auxAck   = grantAux;
  assign arbBus.afWrite  = afWrite_q;
  assign arbBus.afAddr   = afAddr_q;
  assign arbBus.afRead   = afRead_q;
  assign arbBus.afSrc    = afSrc_q;
  assign arbBus.rif      = rif_q;
  assign arbBus.halted   = (state_q == HALT);
  assign arbBus.overflow = overflow_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking testbench for mem_req_arbiter.
//
// Directed scenarios with hand-computed expected values.
// Inputs are driven 1ns after each rising edge. Outputs are sampled 1ns
// later, well away from the edge.
module tb_mem_req_arbiter;

  localparam int AW = 26;

  logic clock = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  int   grants;

  mem_req_arbiter_if #(.AW(AW)) bus ();

  mem_req_arbiter #(.MAX_RIF(32), .AW(AW)) dut (
    .clock  (clock),
    .reset  (reset),
    .arbBus (bus)
  );

  // 10ns clock
  always #5 clock = ~clock;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Let freshly driven inputs propagate before sampling.
  task automatic applyStimulus();
    #1;
  endtask

  // Move to 1ns after the next rising edge.
  task automatic advanceClock();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    bus.ringValid = 1'b0;
    bus.ringAddr  = '0;
    bus.ringRead  = 1'b0;
    bus.dispReq   = 1'b0;
    bus.dispAddr  = '0;
    bus.auxReq    = 1'b0;
    bus.auxAddr   = '0;
    bus.auxRead   = 1'b0;
    bus.inhibit   = 1'b0;
    bus.afFull    = 1'b0;
    bus.rdRetire  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    advanceClock();
    advanceClock();
    reset = 1'b0;
  endtask

  // Global time limit
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset values; a request held during reset must not be acked or issued.
    reset = 1'b1;
    clearInputs();
    advanceClock();
    bus.dispReq  = 1'b1;
    bus.dispAddr = 26'h3AB;
    applyStimulus();
    checkOutput("rstDispAck", 32'(bus.dispAck), 0);
    advanceClock();
    reset = 1'b0;
    bus.dispReq = 1'b0;
    applyStimulus();
    checkOutput("rstAfWrite", 32'(bus.afWrite), 0);
    checkOutput("rstAfAddr", 32'(bus.afAddr), 0);
    checkOutput("rstAfRead", 32'(bus.afRead), 0);
    checkOutput("rstAfSrc", 32'(bus.afSrc), 0);
    checkOutput("rstRif", 32'(bus.rif), 0);
    checkOutput("rstHalted", 32'(bus.halted), 0);
    checkOutput("rstOverflow", 32'(bus.overflow), 0);
    checkOutput("rstAuxAck", 32'(bus.auxAck), 0);

    // Ring read beats display; display wins the next ring-free cycle.
    doReset();
    bus.ringValid = 1'b1;
    bus.ringRead  = 1'b1;
    bus.ringAddr  = 26'h100;
    bus.dispReq   = 1'b1;
    bus.dispAddr  = 26'h200;
    applyStimulus();
    checkOutput("ringWinsDispAck", 32'(bus.dispAck), 0);
    advanceClock();
    bus.ringValid = 1'b0;
    applyStimulus();
    checkOutput("ringIssueWrite", 32'(bus.afWrite), 1);
    checkOutput("ringIssueSrc", 32'(bus.afSrc), 0);
    checkOutput("ringIssueAddr", 32'(bus.afAddr), 32'h100);
    checkOutput("ringIssueRead", 32'(bus.afRead), 1);
    checkOutput("dispAfterRing", 32'(bus.dispAck), 1);
    advanceClock();
    bus.dispReq = 1'b0;
    applyStimulus();
    checkOutput("dispIssueSrc", 32'(bus.afSrc), 1);
    checkOutput("dispIssueAddr", 32'(bus.afAddr), 32'h200);
    checkOutput("rifAfterRing", 32'(bus.rif), 1);
    advanceClock();
    applyStimulus();
    checkOutput("idleAfWrite", 32'(bus.afWrite), 0);
    checkOutput("idleAfAddrHold", 32'(bus.afAddr), 32'h200);
    checkOutput("rifTwo", 32'(bus.rif), 2);

    // Display and aux held together alternate disp, aux, disp, aux.
    doReset();
    bus.dispReq  = 1'b1;
    bus.dispAddr = 26'h11;
    bus.auxReq   = 1'b1;
    bus.auxAddr  = 26'h22;
    bus.auxRead  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      if (i > 0) begin
        checkOutput($sformatf("rrSrc%0d", i - 1), 32'(bus.afSrc),
                    ((i - 1) % 2 == 0) ? 1 : 2);
      end
      if (i < 4) begin
        checkOutput($sformatf("rrDispAck%0d", i), 32'(bus.dispAck), (i % 2 == 0) ? 1 : 0);
        checkOutput($sformatf("rrAuxAck%0d", i), 32'(bus.auxAck), (i % 2 == 0) ? 0 : 1);
      end
      advanceClock();
    end

    // Reads-in-flight limit: 32 local reads, then blocked until one retires.
    doReset();
    bus.dispReq  = 1'b1;
    bus.dispAddr = 26'h33;
    grants = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      if (bus.dispAck) grants++;
      advanceClock();
    end
    checkOutput("maxGrants", 32'(grants), 32);
    checkOutput("maxRif", 32'(bus.rif), 32);
    bus.rdRetire = 1'b1;
    applyStimulus();
    checkOutput("maxBlocked", 32'(bus.dispAck), 0);
    advanceClock();
    bus.rdRetire = 1'b0;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (bus.dispAck) grants++;
      advanceClock();
    end
    checkOutput("retireOneGrant", 32'(grants), 1);
    checkOutput("rifBackTo32", 32'(bus.rif), 32);
    bus.dispReq = 1'b0;
    bus.auxReq  = 1'b1;
    bus.auxAddr = 26'h3C;
    bus.auxRead = 1'b1;
    applyStimulus();
    checkOutput("auxReadBlocked", 32'(bus.auxAck), 0);
    bus.auxRead = 1'b0;
    applyStimulus();
    checkOutput("auxWriteAllowed", 32'(bus.auxAck), 1);

    // FIFO full: the ring is still issued, local requests wait.
    doReset();
    bus.afFull    = 1'b1;
    bus.ringValid = 1'b1;
    bus.ringRead  = 1'b0;
    bus.ringAddr  = 26'h44;
    bus.dispReq   = 1'b1;
    bus.dispAddr  = 26'h55;
    applyStimulus();
    checkOutput("fullDispAck0", 32'(bus.dispAck), 0);
    advanceClock();
    bus.ringValid = 1'b0;
    applyStimulus();
    checkOutput("fullRingWrite", 32'(bus.afWrite), 1);
    checkOutput("fullRingAddr", 32'(bus.afAddr), 32'h44);
    checkOutput("fullDispAck1", 32'(bus.dispAck), 0);
    advanceClock();
    bus.afFull = 1'b0;
    applyStimulus();
    checkOutput("fullNoWrite", 32'(bus.afWrite), 0);
    checkOutput("notFullDispAck", 32'(bus.dispAck), 1);
    advanceClock();
    bus.dispReq = 1'b0;
    applyStimulus();
    checkOutput("notFullDispSrc", 32'(bus.afSrc), 1);

    // Drain and halt: rif=3, inhibit with a same-cycle aux grant, three retires.
    doReset();
    bus.ringValid = 1'b1;
    bus.ringRead  = 1'b1;
    bus.ringAddr  = 26'h66;
    for (int i = 0; i < 3; i++) advanceClock();
    bus.ringValid = 1'b0;
    advanceClock();
    applyStimulus();
    checkOutput("drainRif3", 32'(bus.rif), 3);
    bus.inhibit = 1'b1;
    bus.auxReq  = 1'b1;
    bus.auxRead = 1'b0;
    bus.auxAddr = 26'h77;
    applyStimulus();
    checkOutput("inhibitEdgeAck", 32'(bus.auxAck), 1);
    advanceClock();
    bus.auxReq   = 1'b0;
    bus.dispReq  = 1'b1;
    bus.rdRetire = 1'b1;
    applyStimulus();
    checkOutput("inhibitEdgeIssue", 32'(bus.afWrite), 1);
    checkOutput("inhibitEdgeSrc", 32'(bus.afSrc), 2);
    checkOutput("drainNoAck", 32'(bus.dispAck), 0);
    checkOutput("drainNotHalted", 32'(bus.halted), 0);
    advanceClock();
    advanceClock();
    advanceClock();
    bus.rdRetire = 1'b0;
    applyStimulus();
    checkOutput("drainRif0", 32'(bus.rif), 0);
    checkOutput("drainStillNotHalted", 32'(bus.halted), 0);
    advanceClock();
    applyStimulus();
    checkOutput("haltHalted", 32'(bus.halted), 1);
    checkOutput("haltNoAck", 32'(bus.dispAck), 0);
    bus.inhibit = 1'b0;
    advanceClock();
    applyStimulus();
    checkOutput("runHalted", 32'(bus.halted), 0);
    checkOutput("runDispAck", 32'(bus.dispAck), 1);

    // Retire at zero sets a sticky overflow.
    doReset();
    bus.rdRetire = 1'b1;
    advanceClock();
    bus.rdRetire = 1'b0;
    applyStimulus();
    checkOutput("underflowFlag", 32'(bus.overflow), 1);
    checkOutput("underflowRif", 32'(bus.rif), 0);
    for (int i = 0; i < 5; i++) advanceClock();
    checkOutput("overflowSticky", 32'(bus.overflow), 1);
    doReset();
    applyStimulus();
    checkOutput("overflowCleared", 32'(bus.overflow), 0);

    // rif saturates at 63; one more ring read sets overflow.
    bus.ringValid = 1'b1;
    bus.ringRead  = 1'b1;
    for (int i = 0; i < 63; i++) advanceClock();
    bus.ringValid = 1'b0;
    advanceClock();
    advanceClock();
    checkOutput("satRif63", 32'(bus.rif), 63);
    checkOutput("satNoOverflow", 32'(bus.overflow), 0);
    bus.ringValid = 1'b1;
    advanceClock();
    bus.ringValid = 1'b0;
    advanceClock();
    advanceClock();
    checkOutput("satRifHeld", 32'(bus.rif), 63);
    checkOutput("satOverflow", 32'(bus.overflow), 1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
